// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch flushes, data-memory waits.
// Optional perf counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 16,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      ex_mem_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
  input  logic                      mem_select_new_pc,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      fetch_stall,
  output logic                      decode_stall,
  output logic                      decode_flush,
  output logic                      execute_flush,
  output logic                      mem_flush,
  output logic                      pipe_hold,
  output logic                      mem_timeout_err,
  output logic [1:0]                ctrl_state,
  output logic [PERF_WIDTH-1:0]     perf_stall_cycles,
  output logic [PERF_WIDTH-1:0]     perf_flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BRANCH   = 2'd2,
    BAD      = 2'd3
  } state_t;

  localparam logic [3:0] BR_LOAD = 4'(BRANCH_PENALTY - 1);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nx;
  logic [3:0] br_cnt, br_cnt_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic       rs1_hit, rs2_hit;
  logic       load_use, mem_stall;

  assign rs1_hit = id_rs1_used &&
                   (id_rs1_addr == ex_reg_wr_addr);
  assign rs2_hit = id_rs2_used &&
                   (id_rs2_addr == ex_reg_wr_addr);
  assign load_use = ex_mem_rd_en &&
                    (ex_reg_wr_addr != '0) &&
                    (rs1_hit || rs2_hit);
  assign mem_stall = dmem_req && !dmem_ready;

  assign ctrl_state = state;

  always_comb begin
    fetch_stall     = 1'b0;
    decode_stall    = 1'b0;
    decode_flush    = 1'b0;
    execute_flush   = 1'b0;
    mem_flush       = 1'b0;
    pipe_hold       = 1'b0;
    mem_timeout_err = 1'b0;
    state_nx        = state;
    br_cnt_nx       = br_cnt;
    wait_cnt_nx     = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          pipe_hold    = 1'b1;
          fetch_stall  = 1'b1;
          decode_stall = 1'b1;
          wait_cnt_nx  = 8'd1;
          state_nx     = MEM_WAIT;
        end else if (mem_select_new_pc) begin
          decode_flush  = 1'b1;
          execute_flush = 1'b1;
          mem_flush     = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            br_cnt_nx = BR_LOAD;
            state_nx  = BRANCH;
          end
        end else if (load_use) begin
          fetch_stall   = 1'b1;
          decode_stall  = 1'b1;
          execute_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nx = RUN;
        end else if (wait_cnt == TO_LAST) begin
          mem_flush       = 1'b1;
          mem_timeout_err = 1'b1;
          state_nx        = RUN;
        end else begin
          pipe_hold    = 1'b1;
          fetch_stall  = 1'b1;
          decode_stall = 1'b1;
          wait_cnt_nx  = wait_cnt + 8'd1;
        end
      end
      BRANCH: begin
        decode_flush  = 1'b1;
        execute_flush = 1'b1;
        // a fresh redirect restarts the penalty window
        if (mem_select_new_pc) begin
          mem_flush = 1'b1;
          br_cnt_nx = BR_LOAD;
        end else begin
          br_cnt_nx = br_cnt - 4'd1;
          if (br_cnt == 4'd1) state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
    if (rst) begin
      fetch_stall     = 1'b0;
      decode_stall    = 1'b0;
      decode_flush    = 1'b0;
      execute_flush   = 1'b0;
      mem_flush       = 1'b0;
      pipe_hold       = 1'b0;
      mem_timeout_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      br_cnt   <= 4'd0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      br_cnt   <= br_cnt_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  localparam logic [PERF_WIDTH-1:0] PERF_ONE = PERF_WIDTH'(1);

  logic [PERF_WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (fetch_stall && !(&stall_q))
        stall_q <= stall_q + PERF_ONE;
      if (mem_flush && !(&flush_q))
        flush_q <= flush_q + PERF_ONE;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flush_events = flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle model.
// Perf counter checks follow PIPE_HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int BP = 2;
  localparam int TO = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr;
  logic          id_rs1_used, id_rs2_used;
  logic          ex_mem_rd_en;
  logic [AW-1:0] ex_reg_wr_addr;
  logic          mem_select_new_pc;
  logic          dmem_req, dmem_ready;
  logic          fetch_stall, decode_stall;
  logic          decode_flush, execute_flush;
  logic          mem_flush, pipe_hold;
  logic          mem_timeout_err;
  logic [1:0]    ctrl_state;
  logic [PW-1:0] perf_stall_cycles;
  logic [PW-1:0] perf_flush_events;

  int errors = 0;
  int checks = 0;

  // model: stalled cycles of the pending access (0 = none),
  // remaining BRANCH cycles, and running event totals
  int m_wait = 0;
  int m_br   = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH(AW),
    .BRANCH_PENALTY(BP),
    .MEM_TIMEOUT(TO),
    .PERF_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_mem_rd_en(ex_mem_rd_en),
    .ex_reg_wr_addr(ex_reg_wr_addr),
    .mem_select_new_pc(mem_select_new_pc),
    .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .fetch_stall(fetch_stall),
    .decode_stall(decode_stall),
    .decode_flush(decode_flush),
    .execute_flush(execute_flush),
    .mem_flush(mem_flush),
    .pipe_hold(pipe_hold),
    .mem_timeout_err(mem_timeout_err),
    .ctrl_state(ctrl_state),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_events(perf_flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    id_rs1_addr = '0;
    id_rs2_addr = '0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    ex_mem_rd_en = 1'b0;
    ex_reg_wr_addr = '0;
    mem_select_new_pc = 1'b0;
    dmem_req = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // settle mid-cycle, compare all outputs with the model, advance the model
  task automatic settle_check();
    bit lu, fs, ds, df, ef, mf, ph, er;
    int es, nw, nb, xs, xf;
    #4;
    lu = ex_mem_rd_en && ex_reg_wr_addr != 0 &&
         ((id_rs1_used && id_rs1_addr == ex_reg_wr_addr) ||
          (id_rs2_used && id_rs2_addr == ex_reg_wr_addr));
    {fs, ds, df, ef, mf, ph, er} = '0;
    es = 0;
    nw = m_wait;
    nb = m_br;
    if (rst) begin
      nw = 0;
      nb = 0;
    end else if (m_wait > 0) begin
      es = 1;
      if (dmem_ready) nw = 0;
      else if (m_wait == TO - 1) begin
        mf = 1; er = 1; nw = 0;
      end else begin
        ph = 1; fs = 1; ds = 1; nw = m_wait + 1;
      end
    end else if (m_br > 0) begin
      es = 2;
      df = 1; ef = 1;
      if (mem_select_new_pc) begin
        mf = 1; nb = BP - 1;
      end else nb = m_br - 1;
    end else if (dmem_req && !dmem_ready) begin
      ph = 1; fs = 1; ds = 1; nw = 1;
    end else if (mem_select_new_pc) begin
      df = 1; ef = 1; mf = 1; nb = BP - 1;
    end else if (lu) begin
      fs = 1; ds = 1; ef = 1;
    end
    chk("outputs",
        {25'd0, fetch_stall, decode_stall, decode_flush,
         execute_flush, mem_flush, pipe_hold, mem_timeout_err},
        {25'd0, fs, ds, df, ef, mf, ph, er});
    chk("ctrl_state", {30'd0, ctrl_state}, es);
`ifdef PIPE_HAZARD_PERF_EN
    xs = rst ? 0 : m_stall;
    xf = rst ? 0 : m_flush;
`else
    xs = 0;
    xf = 0;
`endif
    chk("perf_stall", perf_stall_cycles, xs);
    chk("perf_flush", perf_flush_events, xf);
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_stall += int'(fs);
      m_flush += int'(mf);
    end
    m_wait = nw;
    m_br = nb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle_check();
    next_cycle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    next_cycle();
    cyc();
    rst = 1'b0;
    cyc();

    // reset while waiting on memory
    dmem_req = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    settle_check();
    chk("rst_hold", {31'd0, pipe_hold}, 32'd0);
    chk("rst_state", {30'd0, ctrl_state}, 32'd0);
    next_cycle();
    idle();
    settle_check();
    chk("post_rst_hold", {31'd0, pipe_hold}, 32'd0);
    next_cycle();
    cyc();

    // load-use on rs2
    ex_mem_rd_en = 1'b1;
    ex_reg_wr_addr = 5'd5;
    id_rs2_addr = 5'd5;
    id_rs2_used = 1'b1;
    settle_check();
    chk("lu_stall",
        {29'd0, fetch_stall, decode_stall, execute_flush}, 32'd7);
    next_cycle();
    ex_reg_wr_addr = 5'd0;
    id_rs2_addr = 5'd0;
    settle_check();
    chk("lu_r0", {31'd0, fetch_stall}, 32'd0);
    next_cycle();
    idle();
    cyc();

    // taken branch, penalty 2
    mem_select_new_pc = 1'b1;
    settle_check();
    chk("br_c0", {29'd0, decode_flush, execute_flush, mem_flush},
        32'd7);
    next_cycle();
    mem_select_new_pc = 1'b0;
    settle_check();
    chk("br_c1", {29'd0, decode_flush, execute_flush, mem_flush},
        32'd6);
    chk("br_c1_state", {30'd0, ctrl_state}, 32'd2);
    next_cycle();
    settle_check();
    chk("br_c2", {29'd0, decode_flush, execute_flush, mem_flush},
        32'd0);
    next_cycle();

    // three wait cycles then ready
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("mw_hold", {31'd0, pipe_hold}, 32'd1);
      next_cycle();
    end
    dmem_ready = 1'b1;
    settle_check();
    chk("mw_release", {30'd0, pipe_hold, mem_timeout_err}, 32'd0);
    next_cycle();
    idle();
    settle_check();
    chk("mw_state", {30'd0, ctrl_state}, 32'd0);
    next_cycle();

    // timeout: 15 held cycles then abort
    dmem_req = 1'b1;
    for (int i = 0; i < TO - 1; i++) begin
      settle_check();
      chk("to_hold", {31'd0, pipe_hold}, 32'd1);
      next_cycle();
    end
    settle_check();
    chk("to_abort", {29'd0, pipe_hold, mem_flush, mem_timeout_err},
        32'd3);
    next_cycle();
    idle();
    settle_check();
    chk("to_pulse", {31'd0, mem_timeout_err}, 32'd0);
    next_cycle();

    // memory wait beats branch beats load-use
    mem_select_new_pc = 1'b1;
    dmem_req = 1'b1;
    ex_mem_rd_en = 1'b1;
    ex_reg_wr_addr = 5'd3;
    id_rs1_addr = 5'd3;
    id_rs1_used = 1'b1;
    settle_check();
    chk("pri_c0", {30'd0, pipe_hold, mem_flush}, 32'd2);
    next_cycle();
    cyc();
    dmem_ready = 1'b1;
    settle_check();
    chk("pri_ready", {30'd0, pipe_hold, mem_flush}, 32'd0);
    next_cycle();
    dmem_req = 1'b0;
    settle_check();
    chk("pri_br", {30'd0, mem_flush, fetch_stall}, 32'd2);
    next_cycle();
    idle();
    cyc();
    cyc();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      id_rs1_addr = AW'($urandom_range(0, 3));
      id_rs2_addr = AW'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom);
      id_rs2_used = 1'($urandom);
      ex_mem_rd_en = 1'($urandom);
      ex_reg_wr_addr = AW'($urandom_range(0, 3));
      mem_select_new_pc = ($urandom_range(0, 4) == 0);
      dmem_req = 1'($urandom);
      dmem_ready = ($urandom_range(0, 3) == 0);
      cyc();
    end

    idle();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
